// File: rtl/instruction_loader.sv
// Boot loader: receives a 16-bit little-endian word count, then program bytes,
// and writes each assembled 32-bit little-endian word to instruction memory.
module instruction_loader #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_byte_in,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam logic [16:0] LP_MAX_WORDS = 17'd1 << DEPTH_LOG2;

   state_t                r_state;
   logic [15:0]           r_len;
   logic [1:0]            r_byte_cnt;
   logic [DEPTH_LOG2:0]   r_word_idx;
   logic [23:0]           r_shift;
   logic                  r_mem_we;
   logic [31:0]           r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic                  w_in_load;
   logic [15:0]           w_len_full;
   logic [DEPTH_LOG2:0]   w_word_idx_nxt;
   logic [15:0]           w_idx_nxt_ext;

   assign w_in_load      = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
   assign o_byte_ready   = w_in_load && !i_start;
   assign w_len_full     = {i_byte_in, r_len[7:0]};
   assign w_word_idx_nxt = r_word_idx + {{DEPTH_LOG2{1'b0}}, 1'b1};
   assign w_idx_nxt_ext  = {{(15 - DEPTH_LOG2){1'b0}}, w_word_idx_nxt};

   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_error     = r_error;

   // Load sequencer: length capture, word assembly and memory write strobes.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_len       <= 16'd0;
         r_byte_cnt  <= 2'd0;
         r_word_idx  <= '0;
         r_shift     <= 24'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         if (i_start) begin
            r_state    <= LEN_LO;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
               end
               LEN_LO: begin
                  if (i_byte_valid) begin
                     r_len[7:0] <= i_byte_in;
                     r_state    <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  if (i_byte_valid) begin
                     r_len[15:8] <= i_byte_in;
                     if (w_len_full == 16'd0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                     end else if ({1'b0, w_len_full} > LP_MAX_WORDS) begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (i_byte_valid) begin
                     // Shifting right leaves byte k of the word at bits [8k+7:8k].
                     if (r_byte_cnt == 2'd3) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= {i_byte_in, r_shift};
                        r_mem_addr  <= {{(29 - DEPTH_LOG2){1'b0}}, r_word_idx, 2'b00};
                        r_word_idx  <= w_word_idx_nxt;
                        r_byte_cnt  <= 2'd0;
                        if (w_idx_nxt_ext == r_len) begin
                           r_state <= DONE;
                        end
                     end else begin
                        r_shift    <= {i_byte_in, r_shift[23:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                     end
                  end
               end
               DONE: begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
               ERR: begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader; a byte-stream model
// derives the expected memory writes and completion flags.
module tb_instruction_loader;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        i_clk;
   logic        i_reset;
   logic        i_start;
   logic [7:0]  i_byte_in;
   logic        i_byte_valid;
   logic        o_byte_ready;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   int  n_checks = 0;
   int  n_fail   = 0;
   wr_t q_got[$];

   instruction_loader #(.DEPTH_LOG2(8)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_byte_in    (i_byte_in),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Capture every memory write away from the active edge.
   always @(negedge i_clk) begin
      if (o_mem_we === 1'b1) q_got.push_back('{addr: o_mem_addr, data: o_mem_wdata});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc = 1'b0;
      for (int g = 0; g < gap; g++) begin
         i_byte_valid = 1'b0;
         tick();
      end
      i_byte_valid = 1'b1;
      i_byte_in    = b;
      for (int c = 0; c < 20 && !acc; c++) begin
         #1;
         acc = o_byte_ready;
         tick();
      end
      i_byte_valid = 1'b0;
      if (!acc) check_eq("byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      i_start      = 1'b1;
      i_byte_valid = 1'b1;
      i_byte_in    = 8'($urandom);
      #1;
      check_eq("ready_during_start", 32'(o_byte_ready), 32'd0);
      tick();
      i_start      = 1'b0;
      i_byte_valid = 1'b0;
      #1;
      check_eq("start_ready", 32'(o_byte_ready), 32'd1);
      check_eq("start_busy", 32'(o_busy), 32'd1);
      check_eq("start_flags", {30'd0, o_done, o_error}, 32'd0);
   endtask

   // Drives one complete load and compares against the stream model.
   task automatic run_load(input byte_q_t bs, input bit gapped);
      int          len;
      int          nexp;
      logic [31:0] w;
      q_got.delete();
      pulse_start();
      len  = int'({bs[1], bs[0]});
      nexp = (len >= 1 && len <= 256) ? len : 0;
      for (int i = 0; i < bs.size(); i++) begin
         send_byte(bs[i], gapped ? int'($urandom_range(1, 2)) : 0);
         if (i == 1 && len == 0) begin
            check_eq("len0_enter", {29'd0, o_mem_we, o_busy, o_done}, 32'd0);
            tick();
            check_eq("len0_done", {29'd0, o_done, o_error, o_byte_ready}, 32'd4);
         end else if (i == 1 && len > 256) begin
            check_eq("ovf_flags", {28'd0, o_error, o_busy, o_done, o_byte_ready}, 32'd8);
         end else if (i == 1) begin
            check_eq("data_busy_ready", {30'd0, o_busy, o_byte_ready}, 32'd3);
         end else if (i == bs.size() - 1 && nexp > 0) begin
            check_eq("last_write", {28'd0, o_mem_we, o_busy, o_done, o_byte_ready}, 32'd12);
            tick();
            check_eq("final_done", {29'd0, o_mem_we, o_busy, o_done}, 32'd1);
         end
      end
      repeat (3) tick();
      check_eq("n_writes", q_got.size(), nexp);
      for (int i = 0; i < nexp && i < q_got.size(); i++) begin
         w = {bs[2 + 4*i + 3], bs[2 + 4*i + 2], bs[2 + 4*i + 1], bs[2 + 4*i]};
         check_eq($sformatf("addr%0d", i), q_got[i].addr, 32'(4 * i));
         check_eq($sformatf("data%0d", i), q_got[i].data, w);
      end
      check_eq("end_done", 32'(o_done), (len <= 256) ? 32'd1 : 32'd0);
      check_eq("end_error", 32'(o_error), (len > 256) ? 32'd1 : 32'd0);
      check_eq("end_busy_ready", {30'd0, o_busy, o_byte_ready}, 32'd0);
      if (nexp > 0) begin
         w = {bs[2 + 4*nexp - 1], bs[2 + 4*nexp - 2], bs[2 + 4*nexp - 3], bs[2 + 4*nexp - 4]};
         check_eq("hold_addr", o_mem_addr, 32'(4 * (nexp - 1)));
         check_eq("hold_wdata", o_mem_wdata, w);
      end
   endtask

   function automatic byte_q_t make_load(input int n);
      byte_q_t     q;
      logic [15:0] l16;
      l16 = 16'(n);
      q.push_back(l16[7:0]);
      q.push_back(l16[15:8]);
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   initial begin
      byte_q_t     bs;
      logic [15:0] l16;
      i_reset = 1'b1; i_start = 1'b0; i_byte_in = 8'd0; i_byte_valid = 1'b0;
      repeat (3) tick();
      i_reset = 1'b0;
      #1;
      check_eq("rst_outs", {26'd0, o_mem_we, o_busy, o_done, o_error, o_byte_ready, 1'b0}, 32'd0);
      check_eq("rst_addr", o_mem_addr, 32'd0);
      check_eq("rst_wdata", o_mem_wdata, 32'd0);

      bs = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      run_load(bs, 1'b0);
      run_load(bs, 1'b1);
      bs = '{8'h00, 8'h00};
      run_load(bs, 1'b0);
      bs = '{8'h01, 8'h01};
      run_load(bs, 1'b0);
      run_load(make_load(1), 1'b1);
      run_load(make_load(256), 1'b0);
      for (int t = 0; t < 8; t++) run_load(make_load(int'($urandom_range(1, 6))), $urandom_range(0, 1) == 1);
      l16 = 16'($urandom_range(257, 65535));
      bs = '{l16[7:0], l16[15:8]};
      run_load(bs, 1'b0);

      // Restart in the middle of a word: nothing written, then a fresh load.
      q_got.delete();
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      pulse_start();
      repeat (3) tick();
      check_eq("restart_no_write", q_got.size(), 0);
      run_load(make_load(1), 1'b0);

      // Reset during DATA after one completed word.
      q_got.delete();
      pulse_start();
      send_byte(8'h03, 0); send_byte(8'h00, 0);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      #1;
      check_eq("midrst_outs", {27'd0, o_mem_we, o_busy, o_done, o_error, o_byte_ready}, 32'd0);
      check_eq("midrst_addr", o_mem_addr, 32'd0);
      check_eq("midrst_wdata", o_mem_wdata, 32'd0);
      i_byte_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_byte_in = 8'($urandom);
         #1;
         check_eq("midrst_ignore", 32'(o_byte_ready), 32'd0);
         tick();
      end
      i_byte_valid = 1'b0;
      repeat (2) tick();
      check_eq("midrst_writes", q_got.size(), 1);
      check_eq("midrst_idle", {30'd0, o_busy, o_done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Sequential boot loader that fills the instruction memory from a byte stream (UART or testbench). It receives a 16-bit little-endian word count followed by the program bytes, assembles each group of four bytes into a 32-bit instruction, and issues one write per word. Addresses are byte addresses on word boundaries, matching the memory's `read_address[9:2]` indexing. It sits between the byte source and the write port of the instruction memory, and holds the CPU in reset while a load is in progress.

## Interface

- `DEPTH_LOG2`, default 8. Log2 of the memory depth in words (256 words).
- `clk` input, 1 bit. Single clock; all state updates on the rising edge.
- `reset` input, 1 bit. Synchronous, active-high.
- `start` input, 1 bit. Single-cycle pulse that begins, or restarts, a load.
- `byte_in` input, 8 bits. Stream data.
- `byte_valid` input, 1 bit. `byte_in` is valid this cycle.
- `byte_ready` output, 1 bit. Loader accepts a byte this cycle. A byte is transferred on `byte_valid && byte_ready`.
- `mem_we` output, 1 bit. Write strobe to instruction memory, one cycle per word.
- `mem_addr` output, 32 bits. Byte address equal to `word_idx*4`; bits [1:0] are always 0.
- `mem_wdata` output, 32 bits. Assembled instruction.
- `busy` output, 1 bit. Load in progress; also drives the CPU hold.
- `done` output, 1 bit. Load completed successfully.
- `error` output, 1 bit. Word count exceeds `2**DEPTH_LOG2`.

## Operation

- **States:** IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- **Reset:** state goes to IDLE. `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done` and `error` are all 0. The byte counter, word index and length register are cleared.
- **`byte_ready`:** combinational. It equals 1 when the state is LEN_LO, LEN_HI or DATA **and** `start` is 0.
- **`start`:** wins over everything except `reset`, from any state.
  - Next state is LEN_LO.
  - Word index, byte count, `done` and `error` are cleared.
  - Any byte presented in the same cycle is not accepted.
- **LEN_LO:** on transfer, `len[7:0] <= byte_in`, then go to LEN_HI.
- **LEN_HI:** on transfer, `len[15:8] <= byte_in`. The next state depends on the full 16-bit length `{byte_in, len[7:0]}`:
  - 0: go to DONE with no writes.
  - Greater than `2**DEPTH_LOG2`: go to ERR.
  - Otherwise: go to DATA.
- **DATA:** bytes are little-endian. Byte k of a word (k = 0..3) goes to `shift[8k+7:8k]`.
  - On the 4th byte, the next edge registers the following and advances the word index:
    - `mem_wdata` = assembled word
    - `mem_addr` = `word_idx << 2`
    - `mem_we` = 1
  - `mem_we` is high for exactly that one cycle.
  - `byte_ready` stays high during the write cycle, so back-to-back bytes are accepted with no stall.
  - When the word index reaches `len` on that edge, next state is DONE. The final `mem_we` pulse occurs in the first DONE cycle.
- **DONE:** `byte_ready` = 0. `done` rises on the cycle after the final `mem_we` pulse, or the cycle after entering DONE when `len` = 0. It holds until `start` or `reset`.
- **ERR:** `error` = 1, `byte_ready` = 0, no writes. Held until `start` or `reset`.
- **`busy`:** 1 in LEN_LO, LEN_HI and DATA, and also during the final write cycle in DONE; 0 otherwise.
- **Counters and widths:**
  - Word index is `DEPTH_LOG2+1` bits wide and never wraps; the length is checked before entering DATA.
  - `mem_addr` is zero-extended to 32 bits.
- **Aborts:** a `start` or `reset` during DATA discards a partially assembled word. Words already written are not rolled back.
- **Idle outputs:** `mem_addr` and `mem_wdata` keep their last values while `mem_we` = 0.

## Timing

- **Byte-to-write latency:** the 4th byte of a word is accepted at edge T; `mem_we` is high in the cycle following T.
- **Minimum load time:** N words with continuous `byte_valid` take 2 + 4N accept cycles, plus 1 write cycle, plus 1 cycle until `done`.
- **Gaps:** gaps in `byte_valid` stall only the assembly; no state advances without a transfer.
- **Start pulse:** `start` asserted at edge T gives LEN_LO and `byte_ready` = 1 from T+1.
- **Reset:** `reset` overrides `start` in the same cycle.

## Test plan

- **Two-word load:** `start`, then bytes 02 00 13 05 A0 00 93 05 10 00 → `mem_we` pulses twice:
  - addr 0x0, data 0x00A00513
  - addr 0x4, data 0x00100593
  - `done` = 1 one cycle after the second pulse; `busy` falls at the same point.
- **Zero length:** `start`, then 00 00 → no `mem_we`, `done` = 1, `error` = 0, `byte_ready` = 0 afterward.
- **Overflow:** `start`, then 01 01 (len = 257) → `error` = 1, no writes, `done` = 0. A subsequent `start` clears `error`.
- **Gapped stream:** load of 1 word with `byte_valid` toggled every other cycle → identical data and address to the continuous case; exactly one `mem_we`.
- **Restart mid-word:** after len = 2 and 2 data bytes, pulse `start` with `byte_valid` = 1 → that byte is not accepted and no `mem_we` is issued. A fresh load of 1 word writes addr 0x0 with the new data.
- **Reset mid-load:** `reset` during DATA → the next cycle shows IDLE, all outputs 0, `byte_ready` = 0; later bytes are ignored until `start`.
